// File: rtl/testbench_seq.sv
// Stimulus/compare core: issues operand pairs to an external DUT, checks the delayed results
// against the selected operation and keeps saturating counters plus a first-error snapshot.
module testbench_seq #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned CTR_W   = 32,
    parameter int unsigned DUT_LAT = 1,
    parameter logic [31:0] SEED_A  = 32'hCAFEF00D,
    parameter logic [31:0] SEED_B  = 32'hFEEDC0DE,
    parameter logic [31:0] TAPS    = 32'h80200003
) (
    input  logic             clk_dut,
    input  logic             reset,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic             i_freeze,
    input  logic [1:0]       i_op,
    input  logic             i_pat,
    input  logic [CTR_W-1:0] i_num_vec,
    output logic [WIDTH-1:0] o_drive_a,
    output logic [WIDTH-1:0] o_drive_b,
    output logic             o_drive_valid,
    input  logic [WIDTH-1:0] i_dut_out,
    output logic             o_busy,
    output logic             o_done,
    output logic [CTR_W-1:0] o_data_ctr,
    output logic [CTR_W-1:0] o_err_ctr,
    output logic             o_err_seen,
    output logic [WIDTH-1:0] o_err_a,
    output logic [WIDTH-1:0] o_err_b,
    output logic [WIDTH-1:0] o_err_got
);

    localparam logic [WIDTH-1:0] SeedARaw = SEED_A[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SeedBRaw = SEED_B[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SeedA    = (SeedARaw == '0) ? WIDTH'(1) : SeedARaw;
    localparam logic [WIDTH-1:0] SeedB    = (SeedBRaw == '0) ? WIDTH'(1) : SeedBRaw;
    localparam logic [WIDTH-1:0] TapsW    = TAPS[WIDTH-1:0];

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic               pat_q, pat_d;
    logic [CTR_W-1:0]   num_q, num_d;
    logic [CTR_W-1:0]   issued_q, issued_d;
    logic               valid_q, valid_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic               flush, clear;

    logic [DUT_LAT-1:0] pipe_v_q;
    logic [WIDTH-1:0]   pipe_a_q [DUT_LAT];
    logic [WIDTH-1:0]   pipe_b_q [DUT_LAT];

    logic [WIDTH-1:0]   tail_a, tail_b, expected;
    logic               cmp_v, mismatch;

    logic [CTR_W-1:0]   data_ctr_q, err_ctr_q;
    logic               err_seen_q;
    logic [WIDTH-1:0]   err_a_q, err_b_q, err_got_q;

    // Right-shifting Galois step: feedback mask applied when the bit shifted out is 1.
    function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] x);
        return x[0] ? ((x >> 1) ^ TapsW) : (x >> 1);
    endfunction

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        pat_d    = pat_q;
        num_d    = num_q;
        issued_d = issued_q;
        valid_d  = valid_q;
        a_d      = a_q;
        b_d      = b_q;
        flush    = 1'b0;
        clear    = 1'b0;
        case (state_q)
            StIdle, StDone: begin
                if (i_start && !i_abort) begin
                    state_d  = StRun;
                    op_d     = i_op;
                    pat_d    = i_pat;
                    num_d    = i_num_vec;
                    issued_d = CTR_W'(1);
                    valid_d  = 1'b1;
                    a_d      = i_pat ? '0 : SeedA;
                    b_d      = i_pat ? '0 : SeedB;
                    clear    = 1'b1;
                end
            end
            StRun: begin
                if (i_abort) begin
                    state_d = StDone;
                    valid_d = 1'b0;
                    flush   = 1'b1;
                end else if (num_q != '0 && issued_q == num_q) begin
                    state_d = StDrain;
                    valid_d = 1'b0;
                end else begin
                    issued_d = issued_q + CTR_W'(1);
                    a_d      = pat_q ? a_q + WIDTH'(1) : lfsr_next(a_q);
                    b_d      = pat_q ? b_q + WIDTH'(1) : lfsr_next(b_q);
                end
            end
            StDrain: begin
                if (i_abort) begin
                    state_d = StDone;
                    flush   = 1'b1;
                end else if (pipe_v_q == '0) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_dut) begin
        if (!reset) begin
            state_q  <= StIdle;
            op_q     <= '0;
            pat_q    <= 1'b0;
            num_q    <= '0;
            issued_q <= '0;
            valid_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            pat_q    <= pat_d;
            num_q    <= num_d;
            issued_q <= issued_d;
            valid_q  <= valid_d;
            a_q      <= a_d;
            b_q      <= b_d;
        end
    end

    // Delay line mirrors the DUT pipeline; tail entry lines up with i_dut_out.
    always_ff @(posedge clk_dut) begin
        if (!reset || flush) begin
            pipe_v_q <= '0;
        end else begin
            pipe_v_q[0] <= valid_q;
            for (int i = 1; i < int'(DUT_LAT); i++) pipe_v_q[i] <= pipe_v_q[i-1];
        end
    end

    always_ff @(posedge clk_dut) begin
        pipe_a_q[0] <= a_q;
        pipe_b_q[0] <= b_q;
        for (int i = 1; i < int'(DUT_LAT); i++) begin
            pipe_a_q[i] <= pipe_a_q[i-1];
            pipe_b_q[i] <= pipe_b_q[i-1];
        end
    end

    always_comb begin
        tail_a = pipe_a_q[DUT_LAT-1];
        tail_b = pipe_b_q[DUT_LAT-1];
        cmp_v  = pipe_v_q[DUT_LAT-1];
        case (op_q)
            2'd0:    expected = tail_a + tail_b;
            2'd1:    expected = tail_a - tail_b;
            2'd2:    expected = tail_a * tail_b;
            default: expected = tail_a ^ tail_b;
        endcase
        mismatch = cmp_v && (i_dut_out != expected);
    end

    always_ff @(posedge clk_dut) begin
        if (!reset || clear) begin
            data_ctr_q <= '0;
            err_ctr_q  <= '0;
            err_seen_q <= 1'b0;
            err_a_q    <= '0;
            err_b_q    <= '0;
            err_got_q  <= '0;
        end else if (cmp_v && !i_freeze) begin
            if (data_ctr_q != '1) data_ctr_q <= data_ctr_q + CTR_W'(1);
            if (mismatch && err_ctr_q != '1) err_ctr_q <= err_ctr_q + CTR_W'(1);
            if (mismatch && !err_seen_q) begin
                err_seen_q <= 1'b1;
                err_a_q    <= tail_a;
                err_b_q    <= tail_b;
                err_got_q  <= i_dut_out;
            end
        end
    end

    assign o_drive_a     = a_q;
    assign o_drive_b     = b_q;
    assign o_drive_valid = valid_q;
    assign o_busy        = (state_q == StRun) || (state_q == StDrain);
    assign o_done        = (state_q == StDone);
    assign o_data_ctr    = data_ctr_q;
    assign o_err_ctr     = err_ctr_q;
    assign o_err_seen    = err_seen_q;
    assign o_err_a       = err_a_q;
    assign o_err_b       = err_b_q;
    assign o_err_got     = err_got_q;

endmodule

// File: tb/tb_testbench_seq.sv
// Randomised bench for testbench_seq: a transaction-level model with a queue of in-flight
// vectors is compared against the DUT every cycle, plus hand-computed literal checks.
module tb_testbench_seq;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        i_start = 1'b0, i_abort = 1'b0, i_freeze = 1'b0, i_pat = 1'b0;
    logic [1:0]  i_op = '0;
    logic [31:0] i_num_vec = '0;
    logic [31:0] o_drive_a, o_drive_b, dut_out, o_err_a, o_err_b, o_err_got;
    logic [31:0] o_data_ctr, o_err_ctr;
    logic        o_drive_valid, o_busy, o_done, o_err_seen;

    // Saturation instance: 2-bit counters, single-cycle DUT that is always wrong.
    logic        s_start = 1'b0, s_abort = 1'b0;
    logic [1:0]  s_num = '0;
    logic [31:0] s_drive_a, s_drive_b, s_err_a, s_err_b, s_err_got;
    logic [1:0]  s_data_ctr, s_err_ctr;
    logic        s_drive_valid, s_busy, s_done, s_err_seen;

    int          n_cmp = 0, n_bad = 0, cyc = 0;
    bit          chk_en = 1'b0;

    always #5 clk = ~clk;

    testbench_seq #(.WIDTH(32), .CTR_W(32), .DUT_LAT(LAT)) u_dut (
        .clk_dut(clk), .reset(reset), .i_start(i_start), .i_abort(i_abort),
        .i_freeze(i_freeze), .i_op(i_op), .i_pat(i_pat), .i_num_vec(i_num_vec),
        .o_drive_a(o_drive_a), .o_drive_b(o_drive_b), .o_drive_valid(o_drive_valid),
        .i_dut_out(dut_out), .o_busy(o_busy), .o_done(o_done), .o_data_ctr(o_data_ctr),
        .o_err_ctr(o_err_ctr), .o_err_seen(o_err_seen), .o_err_a(o_err_a), .o_err_b(o_err_b),
        .o_err_got(o_err_got)
    );

    testbench_seq #(.WIDTH(32), .CTR_W(2), .DUT_LAT(1)) u_sat (
        .clk_dut(clk), .reset(reset), .i_start(s_start), .i_abort(s_abort),
        .i_freeze(1'b0), .i_op(2'd3), .i_pat(1'b1), .i_num_vec(s_num),
        .o_drive_a(s_drive_a), .o_drive_b(s_drive_b), .o_drive_valid(s_drive_valid),
        .i_dut_out(32'hFFFF_FFFF), .o_busy(s_busy), .o_done(s_done), .o_data_ctr(s_data_ctr),
        .o_err_ctr(s_err_ctr), .o_err_seen(s_err_seen), .o_err_a(s_err_a), .o_err_b(s_err_b),
        .o_err_got(s_err_got)
    );

    function automatic logic [31:0] ref_op(input int op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        logic [31:0] r;
        p = {32'b0, a} * {32'b0, b};
        case (op)
            0:       r = a + b;
            1:       r = a - b;
            2:       r = p[31:0];
            default: r = a ^ b;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] lfsr(input logic [31:0] x);
        return x[0] ? ((x >> 1) ^ 32'h80200003) : (x >> 1);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // External DUT stand-in: LAT-deep pipeline computing dut_op with optional faults.
    int          dut_op = 0;
    bit          dut_bug = 1'b0, dut_noise = 1'b0;
    logic [31:0] dpipe [LAT];
    always @(posedge clk) begin
        dpipe[0] <= ref_op(dut_op, o_drive_a, o_drive_b)
                    + ((dut_bug && o_drive_a == 32'd2) ? 32'd1 : 32'd0)
                    ^ ((dut_noise && ($urandom % 3 == 0)) ? 32'd1 : 32'd0);
        for (int i = 1; i < LAT; i++) dpipe[i] <= dpipe[i-1];
    end
    assign dut_out = dpipe[LAT-1];

    // Reference model: state 0 idle, 1 run, 2 drain, 3 done; q holds issued vectors in flight.
    typedef struct { logic [31:0] a; logic [31:0] b; int due; } ent_t;
    ent_t        q[$];
    ent_t        ent;
    int          m_st = 0, m_op = 0;
    bit          m_valid = 0, m_pat = 0, m_seen = 0, m_empty, m_busy;
    logic [31:0] m_a = 0, m_b = 0, m_num = 0, m_issued = 0, m_sa = 0, m_sb = 0, m_sg = 0, m_exp;
    longint      m_data = 0, m_err = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("drive_valid", 64'(o_drive_valid), 64'(m_valid));
                chk("drive_a", 64'(o_drive_a), 64'(m_a));
                chk("drive_b", 64'(o_drive_b), 64'(m_b));
                chk("busy", 64'(o_busy), 64'(m_st == 1 || m_st == 2));
                chk("done", 64'(o_done), 64'(m_st == 3));
                chk("data_ctr", 64'(o_data_ctr), 64'(m_data));
                chk("err_ctr", 64'(o_err_ctr), 64'(m_err));
                chk("err_seen", 64'(o_err_seen), 64'(m_seen));
                chk("err_a", 64'(o_err_a), 64'(m_sa));
                chk("err_b", 64'(o_err_b), 64'(m_sb));
                chk("err_got", 64'(o_err_got), 64'(m_sg));
            end
            if (!reset) begin
                m_st = 0; m_valid = 0; m_a = 0; m_b = 0; m_issued = 0; m_num = 0; m_op = 0;
                m_pat = 0; m_data = 0; m_err = 0; m_seen = 0; m_sa = 0; m_sb = 0; m_sg = 0;
                q.delete();
            end else begin
                m_empty = (q.size() == 0);
                m_busy  = (m_st == 1 || m_st == 2);
                if (q.size() > 0 && q[0].due == cyc) begin
                    ent   = q.pop_front();
                    m_exp = ref_op(m_op, ent.a, ent.b);
                    if (!i_freeze) begin
                        if (m_data < 64'hFFFF_FFFF) m_data++;
                        if (dut_out !== m_exp) begin
                            if (m_err < 64'hFFFF_FFFF) m_err++;
                            if (!m_seen) begin
                                m_seen = 1; m_sa = ent.a; m_sb = ent.b; m_sg = dut_out;
                            end
                        end
                    end
                end
                if (m_valid) begin
                    ent.a = m_a; ent.b = m_b; ent.due = cyc + LAT;
                    q.push_back(ent);
                end
                if (i_abort && m_busy) begin
                    m_st = 3; m_valid = 0; q.delete();
                end else if ((m_st == 0 || m_st == 3) && i_start && !i_abort) begin
                    m_st = 1; m_op = int'(i_op); m_pat = i_pat; m_num = i_num_vec;
                    m_data = 0; m_err = 0; m_seen = 0; m_sa = 0; m_sb = 0; m_sg = 0;
                    m_valid = 1; m_issued = 1;
                    m_a = i_pat ? 32'd0 : 32'hCAFEF00D;
                    m_b = i_pat ? 32'd0 : 32'hFEEDC0DE;
                end else if (m_st == 1) begin
                    if (m_num != 0 && m_issued == m_num) begin
                        m_st = 2; m_valid = 0;
                    end else begin
                        m_issued = m_issued + 1;
                        m_a = m_pat ? m_a + 32'd1 : lfsr(m_a);
                        m_b = m_pat ? m_b + 32'd1 : lfsr(m_b);
                    end
                end else if (m_st == 2 && m_empty) begin
                    m_st = 3;
                end
            end
            cyc++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 300 && !o_done; i++) tick(1);
        chk(name, 64'(o_done), 64'd1);
    endtask

    task automatic run(input int op, input bit pat, input int num);
        i_op = 2'(op); i_pat = pat; i_num_vec = 32'(num);
        i_start = 1'b1;
        tick(1);
        i_start = 1'b0;
        wait_done("run_done");
    endtask

    int stop_at;

    initial begin
        tick(3);
        reset = 1'b1;
        chk_en = 1'b1;
        chk("reset_busy", 64'(o_busy), 64'd0);
        chk("reset_data", 64'(o_data_ctr), 64'd0);

        // Correct adder, incrementing pattern
        dut_op = 0;
        run(0, 1'b1, 4);
        chk("t1_data", 64'(o_data_ctr), 64'd4);
        chk("t1_err", 64'(o_err_ctr), 64'd0);
        chk("t1_seen", 64'(o_err_seen), 64'd0);

        // Adder wrong only for a==2
        dut_bug = 1'b1;
        run(0, 1'b1, 4);
        dut_bug = 1'b0;
        chk("t2_data", 64'(o_data_ctr), 64'd4);
        chk("t2_err", 64'(o_err_ctr), 64'd1);
        chk("t2_snap", {o_err_a[15:0], o_err_b[15:0], o_err_got}, {16'd2, 16'd2, 32'd5});

        dut_op = 1;
        run(1, 1'b1, 2);
        chk("t3_sub_data", 64'(o_data_ctr), 64'd2);
        chk("t3_sub_err", 64'(o_err_ctr), 64'd0);
        dut_op = 3;
        run(2, 1'b1, 2);
        chk("t3_mul_err", 64'(o_err_ctr), 64'd1);
        chk("t3_mul_snap", {o_err_a[15:0], o_err_b[15:0], o_err_got}, {16'd1, 16'd1, 32'd0});

        // Continuous LFSR run, aborted during the 10th drive cycle
        dut_op = 0;
        i_op = 2'd0; i_pat = 1'b0; i_num_vec = 32'd0; i_start = 1'b1;
        tick(1);
        i_start = 1'b0;
        chk("t4_vec0", {o_drive_a, o_drive_b}, 64'hCAFEF00D_FEEDC0DE);
        tick(1);
        chk("t4_vec1", {o_drive_a, o_drive_b}, 64'hE55F7805_7F76E06F);
        tick(8);
        i_abort = 1'b1;
        tick(1);
        i_abort = 1'b0;
        chk("t4_done", 64'(o_done), 64'd1);
        chk("t4_valid", 64'(o_drive_valid), 64'd0);
        tick(6);
        chk("t4_data", 64'(o_data_ctr), 64'(10 - LAT));

        // Freeze over two compare cycles
        i_op = 2'd0; i_pat = 1'b1; i_num_vec = 32'd6; i_start = 1'b1;
        tick(1);
        i_start = 1'b0;
        tick(4);
        i_freeze = 1'b1;
        tick(2);
        i_freeze = 1'b0;
        wait_done("t5_done");
        chk("t5_data", 64'(o_data_ctr), 64'd4);

        // Reset mid-run, then restart from the seeds
        i_start = 1'b1;
        tick(1);
        i_start = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(1);
        chk("t5_rst_state", {62'd0, o_busy, o_done}, 64'd0);
        chk("t5_rst_out", {o_drive_a, o_data_ctr}, 64'd0);
        reset = 1'b1;
        i_pat = 1'b0; i_num_vec = 32'd2; i_start = 1'b1;
        tick(1);
        i_start = 1'b0;
        chk("t5_restart", {o_drive_a, o_drive_b}, 64'hCAFEF00D_FEEDC0DE);
        wait_done("t5_restart_done");

        // Saturating 2-bit counters
        s_num = 2'd3; s_start = 1'b1;
        tick(1);
        s_start = 1'b0;
        for (int i = 0; i < 50 && !s_done; i++) tick(1);
        chk("t6_done", 64'(s_done), 64'd1);
        chk("t6_ctrs", {60'd0, s_data_ctr, s_err_ctr}, 64'hF);
        chk("t6_snap", {s_err_a[15:0], s_err_b[15:0], s_err_got}, {32'd0, 32'hFFFF_FFFF});
        s_num = 2'd0; s_start = 1'b1;
        tick(1);
        s_start = 1'b0;
        tick(10);
        s_abort = 1'b1;
        tick(1);
        s_abort = 1'b0;
        tick(2);
        chk("t6_sat", {59'd0, s_err_seen, s_data_ctr, s_err_ctr}, 64'h1F);
        chk("t6_snap_hold", {s_err_a, s_err_b}, 64'd0);

        // Randomised runs, checked cycle by cycle against the model
        for (int r = 0; r < 40; r++) begin
            i_op = 2'($urandom % 4);
            i_pat = 1'($urandom % 2);
            i_num_vec = $urandom_range(0, 12);
            dut_op = ($urandom % 3 == 0) ? int'($urandom % 4) : int'(i_op);
            dut_noise = ($urandom % 4 == 0);
            stop_at = (i_num_vec == 0) ? int'($urandom_range(3, 30)) : 1000;
            i_start = 1'b1;
            tick(1);
            for (int c = 0; c < 200 && !o_done; c++) begin
                i_freeze = ($urandom % 8 == 0);
                i_start = ($urandom % 10 == 0);
                i_abort = (c == stop_at) || ($urandom % 50 == 0);
                if ($urandom % 100 == 0) begin
                    reset = 1'b0;
                    tick(1);
                    reset = 1'b1;
                    break;
                end
                tick(1);
            end
            i_freeze = 1'b0; i_start = 1'b0; i_abort = 1'b0;
            tick(1);
            chk("rand_run_ended", 64'(o_busy), 64'd0);
        end
        dut_noise = 1'b0;
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
